// File: rtl/eth_rx_framer.sv
// MAC receive framer: copies each frame's leading bytes into a header ring in data memory,
// streams the remaining bytes into a 33-bit write FIFO and closes every frame with a trailer.
module eth_rx_framer #(
    parameter int unsigned HDR_BYTES   = 16,
    parameter int unsigned FIFO_START  = 14,
    parameter int unsigned AW          = 10,
    parameter int unsigned RING_BASE   = 768,
    parameter int unsigned RING_WORDS  = 256,
    parameter int unsigned MAX_PENDING = 31,
    parameter int unsigned MAX_FRAME   = 1518,
    localparam int unsigned CW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clientRXclock,
    input  logic          reset,
    input  logic [7:0]    RXdata,
    input  logic          RXdataValid,
    input  logic          RXgoodFrame,
    input  logic          RXbadFrame,
    input  logic          headerRead,
    output logic [AW-1:0] receiverAddress,
    output logic [31:0]   receiverData,
    output logic          receiverWrite,
    output logic [CW-1:0] headerCount,
    output logic          headerCountNonZero,
    output logic [32:0]   fifoData,
    output logic          fifoWrite,
    input  logic          fifoFull,
    output logic [15:0]   droppedFrames
);

    localparam int unsigned HdrWords = HDR_BYTES / 4;
    localparam int unsigned HWW      = $clog2(HdrWords + 1);

    localparam logic [13:0]   HdrBytesW  = 14'(HDR_BYTES);
    localparam logic [13:0]   FifoStartW = 14'(FIFO_START);
    localparam logic [13:0]   MaxFrameW  = 14'(MAX_FRAME);
    localparam logic [CW-1:0] MaxPendW   = CW'(MAX_PENDING);
    localparam logic [AW-1:0] RingBaseW  = AW'(RING_BASE);
    localparam logic [AW:0]   RingEndW   = (AW + 1)'(RING_BASE + RING_WORDS - 1);
    localparam logic [AW:0]   RingWordsW = (AW + 1)'(RING_WORDS);
    localparam logic [AW:0]   SlotWordsW = (AW + 1)'(HdrWords);

    typedef enum logic [2:0] {
        StIdle,
        StFrame,
        StWaitStat,
        StTrailer,
        StDiscard
    } state_e;

    state_e         state_q, state_d;
    logic           valid_q;
    logic [13:0]    n_q, n_d;
    logic [31:0]    hdr_word_q, hdr_word_d;
    logic [31:0]    rx_data_q, rx_data_d;
    logic           hdr_pend_q, hdr_pend_d;
    logic [HWW-1:0] hdr_words_q, hdr_words_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  slot_base_q, slot_base_d;
    logic [31:0]    fifo_word_q, fifo_word_d;
    logic [1:0]     f_lane_q, f_lane_d;
    logic           fifo_pend_q, fifo_pend_d;
    logic [31:0]    fifo_data_q, fifo_data_d;
    logic [2:0]     fifo_bcnt_q, fifo_bcnt_d;
    logic [13:0]    fifo_bytes_q, fifo_bytes_d;
    logic           ovf_q, ovf_d;
    logic           trunc_q, trunc_d;
    logic           stat_seen_q, stat_seen_d;
    logic           good_q, good_d;
    logic           bad_q, bad_d;
    logic [CW-1:0]  hcnt_q, hcnt_d;
    logic [15:0]    drop_q, drop_d;
    logic           hr1_q, hr2_q, hr3_q;

    logic           take;
    logic           hdr_inc;
    logic           hdr_dec;
    logic [13:0]    n_cur;
    logic [31:0]    hw;
    logic [31:0]    fw;
    logic [1:0]     ln;

    // Advance a ring address by k words, wrapping back to the ring base.
    function automatic logic [AW-1:0] ring_add(input logic [AW-1:0] a, input logic [AW:0] k);
        logic [AW:0] s;
        s = {1'b0, a} + k;
        if (s > RingEndW) begin
            s = s - RingWordsW;
        end
        return s[AW-1:0];
    endfunction

    assign hdr_dec = hr2_q ^ hr3_q;

    // Next-state logic: frame FSM, byte packing, ring address, counters.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        hdr_word_d   = hdr_word_q;
        rx_data_d    = rx_data_q;
        hdr_pend_d   = 1'b0;
        hdr_words_d  = hdr_words_q;
        addr_d       = addr_q;
        slot_base_d  = slot_base_q;
        fifo_word_d  = fifo_word_q;
        f_lane_d     = f_lane_q;
        fifo_pend_d  = 1'b0;
        fifo_data_d  = fifo_data_q;
        fifo_bcnt_d  = fifo_bcnt_q;
        fifo_bytes_d = fifo_bytes_q;
        ovf_d        = ovf_q;
        trunc_d      = trunc_q;
        stat_seen_d  = stat_seen_q;
        good_d       = good_q;
        bad_d        = bad_q;
        hcnt_d       = hcnt_q;
        drop_d       = drop_q;
        take         = 1'b0;
        hdr_inc      = 1'b0;
        n_cur        = n_q;
        hw           = hdr_word_q;
        fw           = fifo_word_q;
        ln           = f_lane_q;

        // Bookkeeping for the writes presented on the outputs this cycle.
        if (hdr_pend_q) begin
            addr_d      = ring_add(addr_q, (AW + 1)'(1));
            hdr_words_d = hdr_words_q + HWW'(1);
            if (hdr_words_q == HWW'(HdrWords - 1)) begin
                hdr_inc = 1'b1;
            end
        end
        if (fifo_pend_q) begin
            if (fifoFull) begin
                ovf_d = 1'b1;
            end else begin
                fifo_bytes_d = fifo_bytes_q + 14'(fifo_bcnt_q);
            end
        end

        // Status may arrive together with the falling edge, before the flush is done.
        if ((state_q == StFrame || state_q == StWaitStat) && !stat_seen_q &&
            (RXgoodFrame || RXbadFrame)) begin
            stat_seen_d = 1'b1;
            good_d      = RXgoodFrame;
            bad_d       = RXbadFrame;
        end

        unique case (state_q)
            StIdle: begin
                if (RXdataValid && !valid_q) begin
                    if (hcnt_q == MaxPendW || fifoFull) begin
                        state_d = StDiscard;
                    end else begin
                        state_d      = StFrame;
                        take         = 1'b1;
                        n_cur        = '0;
                        hw           = '0;
                        fw           = '0;
                        ln           = '0;
                        ovf_d        = 1'b0;
                        trunc_d      = 1'b0;
                        stat_seen_d  = 1'b0;
                        good_d       = 1'b0;
                        bad_d        = 1'b0;
                        fifo_bytes_d = '0;
                        hdr_words_d  = '0;
                        slot_base_d  = addr_q;
                    end
                end
            end
            StFrame: begin
                if (RXdataValid) begin
                    if (n_q == MaxFrameW) begin
                        trunc_d = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end else begin
                    // Flush partial words; unused byte lanes are already zero.
                    if (n_q < HdrBytesW && n_q[1:0] != 2'd0) begin
                        hdr_pend_d = 1'b1;
                        rx_data_d  = hdr_word_q;
                        hdr_word_d = '0;
                    end
                    if (f_lane_q != 2'd0) begin
                        fifo_pend_d = 1'b1;
                        fifo_data_d = fifo_word_q;
                        fifo_bcnt_d = {1'b0, f_lane_q};
                        fifo_word_d = '0;
                        f_lane_d    = '0;
                    end
                    state_d = StWaitStat;
                end
            end
            StWaitStat: begin
                if (stat_seen_q && !hdr_pend_q && !fifo_pend_q) begin
                    // Short frame: skip to the next slot and count its header now.
                    if (hdr_words_q < HWW'(HdrWords)) begin
                        addr_d  = ring_add(slot_base_q, SlotWordsW);
                        hdr_inc = 1'b1;
                    end
                    state_d = StTrailer;
                end
            end
            StTrailer: begin
                if (!fifoFull) begin
                    state_d = StIdle;
                end
            end
            StDiscard: begin
                if (RXgoodFrame || RXbadFrame) begin
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            n_d = n_cur + 14'd1;
            if (n_cur < HdrBytesW) begin
                hw[{~n_cur[1:0], 3'b000} +: 8] = RXdata;
                if (n_cur[1:0] == 2'd3) begin
                    hdr_pend_d = 1'b1;
                    rx_data_d  = hw;
                    hw         = '0;
                end
            end
            if (n_cur >= FifoStartW) begin
                fw[{ln, 3'b000} +: 8] = RXdata;
                if (ln == 2'd3) begin
                    fifo_pend_d = 1'b1;
                    fifo_data_d = fw;
                    fifo_bcnt_d = 3'd4;
                    fw          = '0;
                end
                ln = ln + 2'd1;
            end
            hdr_word_d  = hw;
            fifo_word_d = fw;
            f_lane_d    = ln;
        end

        if (hdr_inc && !hdr_dec) begin
            if (hcnt_q != MaxPendW) begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end else if (hdr_dec && !hdr_inc) begin
            if (hcnt_q != '0) begin
                hcnt_d = hcnt_q - CW'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clientRXclock) begin
        if (reset) begin
            state_q      <= StIdle;
            // Held at 1 so a frame already in progress at reset is not seen as a rising edge.
            valid_q      <= 1'b1;
            n_q          <= '0;
            hdr_word_q   <= '0;
            rx_data_q    <= '0;
            hdr_pend_q   <= 1'b0;
            hdr_words_q  <= '0;
            addr_q       <= RingBaseW;
            slot_base_q  <= RingBaseW;
            fifo_word_q  <= '0;
            f_lane_q     <= '0;
            fifo_pend_q  <= 1'b0;
            fifo_data_q  <= '0;
            fifo_bcnt_q  <= '0;
            fifo_bytes_q <= '0;
            ovf_q        <= 1'b0;
            trunc_q      <= 1'b0;
            stat_seen_q  <= 1'b0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            hcnt_q       <= '0;
            drop_q       <= '0;
            hr1_q        <= 1'b0;
            hr2_q        <= 1'b0;
            hr3_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= RXdataValid;
            n_q          <= n_d;
            hdr_word_q   <= hdr_word_d;
            rx_data_q    <= rx_data_d;
            hdr_pend_q   <= hdr_pend_d;
            hdr_words_q  <= hdr_words_d;
            addr_q       <= addr_d;
            slot_base_q  <= slot_base_d;
            fifo_word_q  <= fifo_word_d;
            f_lane_q     <= f_lane_d;
            fifo_pend_q  <= fifo_pend_d;
            fifo_data_q  <= fifo_data_d;
            fifo_bcnt_q  <= fifo_bcnt_d;
            fifo_bytes_q <= fifo_bytes_d;
            ovf_q        <= ovf_d;
            trunc_q      <= trunc_d;
            stat_seen_q  <= stat_seen_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            hcnt_q       <= hcnt_d;
            drop_q       <= drop_d;
            hr1_q        <= headerRead;
            hr2_q        <= hr1_q;
            hr3_q        <= hr2_q;
        end
    end

    // Outputs; the FIFO strobe is gated by fifoFull so it can never fire into a full FIFO.
    always_comb begin
        receiverAddress    = addr_q;
        receiverData       = rx_data_q;
        receiverWrite      = hdr_pend_q;
        headerCount        = hcnt_q;
        headerCountNonZero = (hcnt_q != '0);
        droppedFrames      = drop_q;
        fifoWrite          = (fifo_pend_q || state_q == StTrailer) && !fifoFull;
        fifoData           = {1'b0, fifo_data_q};
        if (state_q == StTrailer) begin
            fifoData = {1'b1, 14'b0, ovf_q, trunc_q, fifo_bytes_q, good_q, bad_q};
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Directed bench for eth_rx_framer: frames with byte i = i[7:0], hand-computed expectations.
module tb_eth_rx_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  RXdata = 8'h00;
    logic        RXdataValid = 1'b0;
    logic        RXgoodFrame = 1'b0;
    logic        RXbadFrame = 1'b0;
    logic        headerRead = 1'b0;
    logic [9:0]  receiverAddress;
    logic [31:0] receiverData;
    logic        receiverWrite;
    logic [4:0]  headerCount;
    logic        headerCountNonZero;
    logic [32:0] fifoData;
    logic        fifoWrite;
    logic        fifoFull = 1'b0;
    logic [15:0] droppedFrames;

    int n_tests = 0;
    int n_fail  = 0;

    int          n_hw = 0;
    int          n_dw = 0;
    int          n_tr = 0;
    int          n_viol = 0;
    logic [9:0]  hw_addr_log [4096];
    logic [31:0] hw_data_log [4096];
    logic [32:0] dw_log [4096];
    logic [32:0] last_tr = '0;

    int hw0, dw0, tr0, mark;
    int hw_mid, dw_mid, tr_mid;
    logic [9:0] addr_mid;
    logic [4:0] cnt_mid;

    eth_rx_framer dut (
        .clientRXclock      (clk),
        .reset              (reset),
        .RXdata             (RXdata),
        .RXdataValid        (RXdataValid),
        .RXgoodFrame        (RXgoodFrame),
        .RXbadFrame         (RXbadFrame),
        .headerRead         (headerRead),
        .receiverAddress    (receiverAddress),
        .receiverData       (receiverData),
        .receiverWrite      (receiverWrite),
        .headerCount        (headerCount),
        .headerCountNonZero (headerCountNonZero),
        .fifoData           (fifoData),
        .fifoWrite          (fifoWrite),
        .fifoFull           (fifoFull),
        .droppedFrames      (droppedFrames)
    );

    always #5 clk = ~clk;

    // Log every data-memory and FIFO write, sampled mid-cycle.
    always @(negedge clk) begin
        if (receiverWrite) begin
            hw_addr_log[n_hw % 4096] = receiverAddress;
            hw_data_log[n_hw % 4096] = receiverData;
            n_hw = n_hw + 1;
        end
        if (fifoWrite) begin
            if (fifoFull) n_viol = n_viol + 1;
            if (fifoData[32]) begin
                last_tr = fifoData;
                n_tr    = n_tr + 1;
            end else begin
                dw_log[n_dw % 4096] = fifoData;
                n_dw = n_dw + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        hw0 = n_hw;
        dw0 = n_dw;
        tr0 = n_tr;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; RXdataValid = 1'b0; RXgoodFrame = 1'b0; RXbadFrame = 1'b0;
        fifoFull = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Cycle c carries byte c while c < len; status pulse at c == len; fifoFull in [ff_lo, ff_hi).
    task automatic send_frame(input int len, input bit good, input int ff_lo, input int ff_hi,
                              input int tail, output int tr_mark);
        tr_mark = n_tr;
        for (int c = 0; c < len + tail; c++) begin
            @(posedge clk); #1;
            RXdataValid = (c < len);
            RXdata      = (c < len) ? c[7:0] : 8'h00;
            RXgoodFrame = (c == len) && good;
            RXbadFrame  = (c == len) && !good;
            fifoFull    = (c >= ff_lo) && (c < ff_hi);
            if (c == ff_hi - 1) tr_mark = n_tr;
        end
        fifoFull = 1'b0;
    endtask

    task automatic toggle_hr();
        @(posedge clk); #1;
        headerRead = ~headerRead;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Reset state
        check_eq("rst_addr", 64'(receiverAddress), 64'd768);
        check_eq("rst_rdata", 64'(receiverData), 64'd0);
        check_eq("rst_rwrite", 64'(receiverWrite), 64'd0);
        check_eq("rst_fwrite", 64'(fifoWrite), 64'd0);
        check_eq("rst_fdata", 64'(fifoData), 64'd0);
        check_eq("rst_hcnt", 64'(headerCount), 64'd0);
        check_eq("rst_hcnz", 64'(headerCountNonZero), 64'd0);
        check_eq("rst_drop", 64'(droppedFrames), 64'd0);

        // 64-byte good frame
        snap();
        send_frame(64, 1'b1, -1, -1, 20, mark);
        check_eq("f64_hw_n", 64'(n_hw - hw0), 64'd4);
        check_eq("f64_hw_a0", 64'(hw_addr_log[hw0]), 64'd768);
        check_eq("f64_hw_a3", 64'(hw_addr_log[hw0 + 3]), 64'd771);
        check_eq("f64_hw_d0", 64'(hw_data_log[hw0]), 64'h0001_0203);
        check_eq("f64_hw_d3", 64'(hw_data_log[hw0 + 3]), 64'h0C0D_0E0F);
        check_eq("f64_dw_n", 64'(n_dw - dw0), 64'd13);
        check_eq("f64_dw_first", 64'(dw_log[dw0]), 64'h0_1110_0F0E);
        check_eq("f64_dw_last", 64'(dw_log[dw0 + 12]), 64'h0_0000_3F3E);
        check_eq("f64_tr_n", 64'(n_tr - tr0), 64'd1);
        check_eq("f64_tr", 64'(last_tr), 64'h1_0000_00CA);
        check_eq("f64_hcnt", 64'(headerCount), 64'd1);
        check_eq("f64_hcnz", 64'(headerCountNonZero), 64'd1);
        check_eq("f64_addr", 64'(receiverAddress), 64'd772);

        // 6-byte bad frame: partial header, slot skip, no data words
        snap();
        send_frame(6, 1'b0, -1, -1, 20, mark);
        check_eq("f6_hw_n", 64'(n_hw - hw0), 64'd2);
        check_eq("f6_hw_a1", 64'(hw_addr_log[hw0 + 1]), 64'd773);
        check_eq("f6_hw_d1", 64'(hw_data_log[hw0 + 1]), 64'h0405_0000);
        check_eq("f6_dw_n", 64'(n_dw - dw0), 64'd0);
        check_eq("f6_tr", 64'(last_tr), 64'h1_0000_0001);
        check_eq("f6_hcnt", 64'(headerCount), 64'd2);
        check_eq("f6_addr", 64'(receiverAddress), 64'd776);

        // 1600-byte frame, truncated at 1518
        snap();
        send_frame(1600, 1'b1, -1, -1, 20, mark);
        check_eq("f1600_hw_a0", 64'(hw_addr_log[hw0]), 64'd776);
        check_eq("f1600_dw_n", 64'(n_dw - dw0), 64'd376);
        check_eq("f1600_dw_last", 64'(dw_log[(dw0 + 375) % 4096]), 64'h0_EDEC_EBEA);
        check_eq("f1600_tr", 64'(last_tr), 64'h1_0001_1782);
        check_eq("f1600_hcnt", 64'(headerCount), 64'd3);

        // fifoFull for 10 cycles mid-frame: words due at cycles 22 and 26 are lost
        snap();
        send_frame(40, 1'b1, 20, 30, 20, mark);
        check_eq("ovf_dw_n", 64'(n_dw - dw0), 64'd5);
        check_eq("ovf_dw1", 64'(dw_log[(dw0 + 1) % 4096]), 64'h0_1D1C_1B1A);
        check_eq("ovf_dw_last", 64'(dw_log[(dw0 + 4) % 4096]), 64'h0_0000_2726);
        check_eq("ovf_tr", 64'(last_tr), 64'h1_0002_004A);
        check_eq("ovf_hcnt", 64'(headerCount), 64'd4);

        // fifoFull across the flush and trailer: trailer stalls until release
        snap();
        send_frame(20, 1'b1, 21, 36, 30, mark);
        check_eq("stall_tr_held", 64'(mark - tr0), 64'd0);
        check_eq("stall_tr_n", 64'(n_tr - tr0), 64'd1);
        check_eq("stall_dw_n", 64'(n_dw - dw0), 64'd1);
        check_eq("stall_tr", 64'(last_tr), 64'h1_0002_0012);

        // Reset pulsed at byte 20 of a 40-byte frame
        hw_mid = 0; dw_mid = 0; tr_mid = 0; addr_mid = '0; cnt_mid = '0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            RXdataValid = (c < 40);
            RXdata      = (c < 40) ? c[7:0] : 8'h00;
            RXgoodFrame = (c == 40);
            reset       = (c == 20);
            if (c == 21) begin
                hw_mid = n_hw; dw_mid = n_dw; tr_mid = n_tr;
                addr_mid = receiverAddress; cnt_mid = headerCount;
            end
        end
        check_eq("rmid_addr", 64'(addr_mid), 64'd768);
        check_eq("rmid_hcnt", 64'(cnt_mid), 64'd0);
        check_eq("rmid_hw_n", 64'(n_hw - hw_mid), 64'd0);
        check_eq("rmid_dw_n", 64'(n_dw - dw_mid), 64'd0);
        check_eq("rmid_tr_n", 64'(n_tr - tr_mid), 64'd0);
        snap();
        send_frame(64, 1'b1, -1, -1, 20, mark);
        check_eq("rmid_next_a0", 64'(hw_addr_log[hw0 % 4096]), 64'd768);
        check_eq("rmid_next_dw_n", 64'(n_dw - dw0), 64'd13);
        check_eq("rmid_next_tr", 64'(last_tr), 64'h1_0000_00CA);

        // Pending limit, dropped frames and ring wrap
        do_reset();
        for (int f = 0; f < 31; f++) send_frame(16, 1'b1, -1, -1, 15, mark);
        check_eq("pend_hcnt31", 64'(headerCount), 64'd31);
        check_eq("pend_addr", 64'(receiverAddress), 64'd892);
        snap();
        for (int f = 0; f < 33; f++) send_frame(16, 1'b1, -1, -1, 15, mark);
        check_eq("drop_hw_n", 64'(n_hw - hw0), 64'd0);
        check_eq("drop_dw_n", 64'(n_dw - dw0), 64'd0);
        check_eq("drop_tr_n", 64'(n_tr - tr0), 64'd0);
        check_eq("drop_cnt", 64'(droppedFrames), 64'd33);
        check_eq("drop_hcnt", 64'(headerCount), 64'd31);
        toggle_hr();
        check_eq("hr_one", 64'(headerCount), 64'd30);
        for (int t = 0; t < 30; t++) toggle_hr();
        check_eq("hr_drain", 64'(headerCount), 64'd0);
        check_eq("hr_drain_nz", 64'(headerCountNonZero), 64'd0);
        snap();
        for (int f = 0; f < 33; f++) begin
            send_frame(16, 1'b1, -1, -1, 15, mark);
            toggle_hr();
        end
        check_eq("wrap_hw_n", 64'(n_hw - hw0), 64'd132);
        check_eq("wrap_last_a", 64'(hw_addr_log[(n_hw - 1) % 4096]), 64'd1023);
        check_eq("wrap_addr", 64'(receiverAddress), 64'd768);
        check_eq("wrap_hcnt", 64'(headerCount), 64'd0);
        check_eq("wrap_drop", 64'(droppedFrames), 64'd33);

        check_eq("full_write_viol", 64'(n_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
